// File: rtl/riscx_pkg.sv
// Shared constants and types for the multi-cycle RV32I controller.
// Contents: opcode and funct3 constants, ALU operation codes, PC-source and
// write-back select codes, the controller state enum and the latched IR fields.
package riscx_pkg;

  localparam int unsigned ALU_W = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;

  localparam logic [1:0] WB_ALU_SEL = 2'b00;
  localparam logic [1:0] WB_MEM_SEL = 2'b01;
  localparam logic [1:0] WB_PC4_SEL = 2'b10;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  // Only the instruction fields the controller actually decodes are kept.
  typedef struct packed {
    logic       funct7b5;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } ir_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for OP / OP-IMM instructions.
// Ports: is_r_i (R-type, enables SUB), funct3_i, funct7b5_i ->
//        alu_control_o (ALU code), bad_funct_o (unsupported funct3).
module alu_decoder
  import riscx_pkg::*;
(
  input  logic             is_r_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  output logic [ALU_W-1:0] alu_control_o,
  output logic             bad_funct_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    bad_funct_o   = 1'b0;
    case (funct3_i)
      3'b000:  alu_control_o = (is_r_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control_o = ALU_SLT;
      3'b110:  alu_control_o = ALU_OR;
      3'b111:  alu_control_o = ALU_AND;
      default: bad_funct_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM (LOAD, STORE, OP, OP-IMM, BEQ, JAL).
// Sequences FETCH/DECODE/EXECUTE/MEM/WB with a req/ready memory handshake,
// latching the decoded instruction fields at fetch. Outputs are a decode of
// state + IR; ir_write/pc_write in FETCH are qualified by mem_ready so the
// datapath loads on the same edge the fetch completes.
// Inputs : clk, rst_n (async, active-low), instr_in, mem_ready, alu_zero.
// Outputs: mem_req, mem_we, instr_fetch, ir_write, pc_write, pc_write_br,
//          orig_pc, orig_ula, alu_control, reg_write, wb_sel, illegal, bus_err.
// Build option: CTRL_MEM_TIMEOUT_EN adds a per-access wait counter that traps
// with bus_err after MEM_TIMEOUT unanswered request cycles.
module multicycle_control
  import riscx_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_in,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  instr_fetch,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_write_br,
  output logic [1:0]            orig_pc,
  output logic                  orig_ula,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  illegal,
  output logic                  bus_err
);

  state_t           state_q, state_d;
  ir_t              ir_q;
  logic             illegal_q, illegal_d;
  logic             in_access;
  logic             is_r;
  logic [ALU_W-1:0] dec_alu;
  logic             dec_bad;
  logic             unused_in;

  // The branch decision is made in the datapath from pc_write_br and alu_zero.
  assign unused_in = ^{alu_zero, instr_in[31], instr_in[29:15], instr_in[11:7]};

  assign in_access = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign is_r      = (ir_q.opcode == OPC_OP);

  alu_decoder u_alu_decoder (
    .is_r_i        (is_r),
    .funct3_i      (ir_q.funct3),
    .funct7b5_i    (ir_q.funct7b5),
    .alu_control_o (dec_alu),
    .bad_funct_o   (dec_bad)
  );

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q;
  logic             timeout;

  // Last permitted wait cycle still unanswered; a ready in that cycle wins.
  assign timeout = in_access && !mem_ready && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Counter restarts on every state change, so each access gets a fresh budget.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_access && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout;

  // Timeout budget has no effect without the wait counter.
  assign unused_timeout = (MEM_TIMEOUT == 0);
  assign bus_err        = 1'b0;
`endif

  // State, latched instruction fields and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if ((state_q == S_FETCH) && mem_ready) begin
        ir_q <= {instr_in[30], instr_in[14:12], instr_in[6:0]};
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ir_q.opcode)
          OPC_OP:              state_d = dec_bad ? S_TRAP : S_EXEC_R;
          OPC_OP_IMM:          state_d = dec_bad ? S_TRAP : S_EXEC_I;
          OPC_LOAD, OPC_STORE: state_d = S_ADDR;
          OPC_BRANCH:          state_d = (ir_q.funct3 == F3_BEQ) ? S_BRANCH : S_TRAP;
          OPC_JAL:             state_d = S_JUMP;
          default:             state_d = S_TRAP;
        endcase
        illegal_d = (state_d == S_TRAP);
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (ir_q.opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
`ifdef CTRL_MEM_TIMEOUT_EN
    if (timeout) state_d = S_TRAP;
`endif
  end

  // Output decode of state + IR.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    instr_fetch = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_br = 1'b0;
    orig_pc     = PC_PLUS4;
    orig_ula    = 1'b0;
    alu_control = '0;
    reg_write   = 1'b0;
    wb_sel      = WB_ALU_SEL;
    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        instr_fetch = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          orig_pc  = PC_PLUS4;
        end
      end
      S_EXEC_R: alu_control = ALU_CTRL_W'(dec_alu);
      S_EXEC_I: begin
        alu_control = ALU_CTRL_W'(dec_alu);
        orig_ula    = 1'b1;
      end
      S_ADDR: begin
        alu_control = ALU_CTRL_W'(ALU_ADD);
        orig_ula    = 1'b1;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        wb_sel    = WB_ALU_SEL;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM_SEL;
      end
      S_BRANCH: begin
        alu_control = ALU_CTRL_W'(ALU_SUB);
        pc_write_br = 1'b1;
        orig_pc     = PC_BRANCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        orig_pc   = PC_JAL;
        reg_write = 1'b1;
        wb_sel    = WB_PC4_SEL;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the hand-derived
// output vector for each cycle it drives, a negedge monitor pops and compares.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       instr_fetch;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_br;
    logic [1:0] orig_pc;
    logic       orig_ula;
    logic [3:0] alu;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  localparam logic [31:0] JUNK    = 32'hFFFF_FFFF;
  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_SUB   = 32'h4073_02B3;
  localparam logic [31:0] I_SLT   = 32'h0031_A0B3;
  localparam logic [31:0] I_ORI   = 32'h0051_6093;
  localparam logic [31:0] I_ANDI  = 32'h0071_7093;
  localparam logic [31:0] I_LW    = 32'h0001_2083;
  localparam logic [31:0] I_SW    = 32'h0020_A223;
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;
  localparam logic [31:0] I_BNE   = 32'h0020_9463;
  localparam logic [31:0] I_JAL   = 32'h0100_00EF;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;
  localparam logic [31:0] I_XORI  = 32'h0051_4093;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req, mem_we, instr_fetch, ir_write, pc_write, pc_write_br;
  logic [1:0]  orig_pc;
  logic        orig_ula;
  logic [3:0]  alu_control;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        illegal, bus_err;

  outs_t act;
  outs_t exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;

  multicycle_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .instr_fetch (instr_fetch),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_write_br (pc_write_br),
    .orig_pc     (orig_pc),
    .orig_ula    (orig_ula),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, instr_fetch, ir_write, pc_write, pc_write_br,
                orig_pc, orig_ula, alu_control, reg_write, wb_sel, illegal, bus_err};

  function automatic outs_t e_idle();
    outs_t e = '0;
    return e;
  endfunction

  function automatic outs_t e_fetch(input logic rdy);
    outs_t e = '0;
    e.mem_req = 1'b1; e.instr_fetch = 1'b1; e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction

  function automatic outs_t e_alu(input logic [3:0] op, input logic imm);
    outs_t e = '0;
    e.alu = op; e.orig_ula = imm;
    return e;
  endfunction

  function automatic outs_t e_mem(input logic we);
    outs_t e = '0;
    e.mem_req = 1'b1; e.mem_we = we;
    return e;
  endfunction

  function automatic outs_t e_wb(input logic [1:0] sel);
    outs_t e = '0;
    e.reg_write = 1'b1; e.wb_sel = sel;
    return e;
  endfunction

  function automatic outs_t e_branch();
    outs_t e = '0;
    e.alu = 4'b0110; e.pc_write_br = 1'b1; e.orig_pc = 2'b01;
    return e;
  endfunction

  function automatic outs_t e_jump();
    outs_t e = '0;
    e.pc_write = 1'b1; e.orig_pc = 2'b10; e.reg_write = 1'b1; e.wb_sel = 2'b10;
    return e;
  endfunction

  function automatic outs_t e_trap(input logic ill, input logic berr);
    outs_t e = '0;
    e.illegal = ill; e.bus_err = berr;
    return e;
  endfunction

  // Drive one cycle's inputs and queue the output vector expected in that cycle.
  task automatic step(input logic rst, input logic rdy, input logic [31:0] ins,
                      input outs_t e, input string nm);
    rst_n     = rst;
    mem_ready = rdy;
    instr_in  = ins;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Full OP / OP-IMM instruction with zero-wait fetch.
  task automatic run_alu(input logic [31:0] ins, input logic [3:0] op,
                         input logic imm, input string pfx);
    step(1'b1, 1'b1, ins,  e_fetch(1'b1),  {pfx, "_fetch"});
    step(1'b1, 1'b0, JUNK, e_idle(),       {pfx, "_decode"});
    step(1'b1, 1'b0, JUNK, e_alu(op, imm), {pfx, "_exec"});
    step(1'b1, 1'b0, JUNK, e_wb(2'b00),    {pfx, "_wb"});
  endtask

  // Instruction that must trap in DECODE, followed by a reset to recover.
  task automatic run_trap(input logic [31:0] ins, input string pfx);
    step(1'b1, 1'b1, ins,  e_fetch(1'b1),      {pfx, "_fetch"});
    step(1'b1, 1'b0, JUNK, e_idle(),           {pfx, "_decode"});
    step(1'b1, 1'b0, JUNK, e_trap(1'b1, 1'b0), {pfx, "_trap"});
    step(1'b0, 1'b0, JUNK, e_idle(),           {pfx, "_reset"});
    step(1'b1, 1'b0, JUNK, e_idle(),           {pfx, "_release"});
  endtask

  always @(negedge clk) begin
    outs_t e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %05h want %05h", n, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    instr_in  = '0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset: everything low, ready ignored; FETCH one edge after release.
    step(1'b0, 1'b1, JUNK, e_idle(), "reset_hold");
    step(1'b1, 1'b0, JUNK, e_idle(), "reset_release");

    run_alu(I_ADD,  4'b0010, 1'b0, "add");
    run_alu(I_SUB,  4'b0110, 1'b0, "sub");
    run_alu(I_SLT,  4'b0111, 1'b0, "slt");
    run_alu(I_ORI,  4'b0001, 1'b1, "ori");
    run_alu(I_ANDI, 4'b0000, 1'b1, "andi");

    // lw with three wait cycles in MEM_RD: 8 cycles total.
    step(1'b1, 1'b1, I_LW, e_fetch(1'b1),        "lw_fetch");
    step(1'b1, 1'b0, JUNK, e_idle(),             "lw_decode");
    step(1'b1, 1'b0, JUNK, e_alu(4'b0010, 1'b1), "lw_addr");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, JUNK, e_mem(1'b0), "lw_mem_wait");
    step(1'b1, 1'b1, JUNK, e_mem(1'b0),          "lw_mem_done");
    step(1'b1, 1'b0, JUNK, e_wb(2'b01),          "lw_wb");

    // sw with two wait cycles in FETCH: no ir_write until ready.
    step(1'b1, 1'b0, I_SW, e_fetch(1'b0),        "sw_fetch_wait");
    step(1'b1, 1'b0, I_SW, e_fetch(1'b0),        "sw_fetch_wait");
    step(1'b1, 1'b1, I_SW, e_fetch(1'b1),        "sw_fetch");
    step(1'b1, 1'b0, JUNK, e_idle(),             "sw_decode");
    step(1'b1, 1'b0, JUNK, e_alu(4'b0010, 1'b1), "sw_addr");
    step(1'b1, 1'b1, JUNK, e_mem(1'b1),          "sw_mem");

    alu_zero = 1'b1;
    step(1'b1, 1'b1, I_BEQ, e_fetch(1'b1), "beq_fetch");
    step(1'b1, 1'b0, JUNK,  e_idle(),      "beq_decode");
    step(1'b1, 1'b0, JUNK,  e_branch(),    "beq_branch");
    alu_zero = 1'b0;

    step(1'b1, 1'b1, I_JAL, e_fetch(1'b1), "jal_fetch");
    step(1'b1, 1'b0, JUNK,  e_idle(),      "jal_decode");
    step(1'b1, 1'b0, JUNK,  e_jump(),      "jal_jump");

    // Reset asserted while a store is waiting: mem_req drops that cycle.
    step(1'b1, 1'b1, I_SW, e_fetch(1'b1),        "rst_sw_fetch");
    step(1'b1, 1'b0, JUNK, e_idle(),             "rst_sw_decode");
    step(1'b1, 1'b0, JUNK, e_alu(4'b0010, 1'b1), "rst_sw_addr");
    step(1'b1, 1'b0, JUNK, e_mem(1'b1),          "rst_sw_wait");
    step(1'b0, 1'b0, JUNK, e_idle(),             "rst_mid_write");
    step(1'b0, 1'b1, JUNK, e_idle(),             "rst_hold");
    step(1'b1, 1'b0, JUNK, e_idle(),             "rst_release");
    step(1'b1, 1'b1, I_ADD, e_fetch(1'b1),       "rst_refetch");
    step(1'b1, 1'b0, JUNK, e_idle(),             "rst_refetch_decode");
    step(1'b1, 1'b0, JUNK, e_alu(4'b0010, 1'b0), "rst_refetch_exec");
    step(1'b1, 1'b0, JUNK, e_wb(2'b00),          "rst_refetch_wb");

    // Unsupported opcode: sticky illegal, ready pulses ignored until reset.
    step(1'b1, 1'b1, I_ECALL, e_fetch(1'b1),      "ecall_fetch");
    step(1'b1, 1'b0, JUNK,    e_idle(),           "ecall_decode");
    step(1'b1, 1'b0, JUNK,    e_trap(1'b1, 1'b0), "ecall_trap");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, I_ADD, e_trap(1'b1, 1'b0), "ecall_stuck");
    step(1'b0, 1'b0, JUNK, e_idle(), "ecall_reset");
    step(1'b1, 1'b0, JUNK, e_idle(), "ecall_release");

    // Unsupported funct3 on OP-IMM and BRANCH.
    run_trap(I_XORI, "xori");
    run_trap(I_BNE,  "bne");

`ifdef CTRL_MEM_TIMEOUT_EN
    // Ready on the 4th wait cycle completes the fetch.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, I_ADD, e_fetch(1'b0), "to_fetch_wait");
    step(1'b1, 1'b1, I_ADD, e_fetch(1'b1),       "to_ready_wins");
    step(1'b1, 1'b0, JUNK,  e_idle(),            "to_decode");
    step(1'b1, 1'b0, JUNK,  e_alu(4'b0010, 1'b0), "to_exec");
    step(1'b1, 1'b0, JUNK,  e_wb(2'b00),         "to_wb");
    // Four unanswered cycles trap with bus_err.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, I_ADD, e_fetch(1'b0), "to_fetch_starve");
    step(1'b1, 1'b1, I_ADD, e_trap(1'b0, 1'b1), "to_trap");
    step(1'b1, 1'b1, I_ADD, e_trap(1'b0, 1'b1), "to_trap_stuck");
    step(1'b0, 1'b0, JUNK,  e_idle(),           "to_reset");
    step(1'b1, 1'b0, JUNK,  e_idle(),           "to_release");
`else
    // Without the timeout the fetch waits indefinitely.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, I_ADD, e_fetch(1'b0), "long_fetch_wait");
    step(1'b1, 1'b1, I_ADD, e_fetch(1'b1),       "long_fetch_done");
    step(1'b1, 1'b0, JUNK,  e_idle(),            "long_decode");
    step(1'b1, 1'b0, JUNK,  e_alu(4'b0010, 1'b0), "long_exec");
    step(1'b1, 1'b0, JUNK,  e_wb(2'b00),         "long_wb");
`endif

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
